// File: rtl/muldiv_unit_if.sv
// Operand/result bus between the pipeline and the HI/LO multiply/divide unit.
// The master side is the decoder/register file; the slave side is muldiv_unit.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdat;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, hi_we, lo_we, wdat,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdat,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO pair, with busy/done handshake.
// Optional MULDIV_FAST_MUL_EN: multiplies complete in one cycle via a combinational multiplier.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input logic            clk,
    input logic            rst,
    muldiv_unit_if.slave   bus
);
    localparam int W2 = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIN
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [W2-1:0]    acc;
    logic [WIDTH-1:0] opb;
    logic             is_div;
    logic             neg_res;
    logic             neg_rem;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic             busy_r;
    logic             done_r;
    logic             dbz_r;

    logic             signed_op;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             op_div;
    logic             b_zero;

    logic [WIDTH:0]   mul_sum;
    logic [W2-1:0]    mul_next;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem;
    logic [W2-1:0]    div_next;
    logic [W2-1:0]    step_acc;
    logic [W2-1:0]    prod;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;

    // Signed ops run on magnitudes; signs are reapplied when the result is stored.
    always_comb begin
        signed_op = ~bus.op[0];
        a_neg     = signed_op & bus.a[WIDTH-1];
        b_neg     = signed_op & bus.b[WIDTH-1];
        a_mag     = a_neg ? -bus.a : bus.a;
        b_mag     = b_neg ? -bus.b : bus.b;
        op_div    = bus.op[1];
        b_zero    = (bus.b == '0);
    end

    // Multiply: acc = {partial, multiplier}, add multiplicand on LSB then shift right.
    // Divide: acc = {remainder, dividend/quotient}, restoring shift-subtract.
    always_comb begin
        mul_sum  = {1'b0, acc[W2-1:WIDTH]} + (acc[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
        mul_next = {mul_sum, acc[WIDTH-1:1]};
        div_ge   = acc[W2-1] | (acc[W2-2:WIDTH-1] >= opb);
        div_rem  = div_ge ? (acc[W2-2:WIDTH-1] - opb) : acc[W2-2:WIDTH-1];
        div_next = {div_rem, acc[WIDTH-2:0], div_ge};
        step_acc = is_div ? div_next : mul_next;
        prod     = neg_res ? -step_acc : step_acc;
        quot     = neg_res ? -step_acc[WIDTH-1:0] : step_acc[WIDTH-1:0];
        rem      = neg_rem ? -step_acc[W2-1:WIDTH] : step_acc[W2-1:WIDTH];
        res_hi   = is_div ? rem  : prod[W2-1:WIDTH];
        res_lo   = is_div ? quot : prod[WIDTH-1:0];
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [W2-1:0] ext_a;
    logic [W2-1:0] ext_b;
    logic [W2-1:0] fast_prod;

    // Low 2*WIDTH bits of the extended product are correct for both signed and unsigned.
    always_comb begin
        ext_a     = {{WIDTH{a_neg}}, bus.a};
        ext_b     = {{WIDTH{b_neg}}, bus.b};
        fast_prod = ext_a * ext_b;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            acc     <= '0;
            opb     <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            hi_r    <= '0;
            lo_r    <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            dbz_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    dbz_r  <= 1'b0;
                    if (bus.start) begin
                        is_div  <= op_div;
                        neg_res <= a_neg ^ b_neg;
                        neg_rem <= a_neg;
                        cnt     <= CNT_W'(WIDTH);
                        acc     <= {{WIDTH{1'b0}}, (op_div ? a_mag : b_mag)};
                        opb     <= op_div ? b_mag : a_mag;
                        busy_r  <= 1'b1;
                        if (op_div && b_zero) begin
                            state  <= FIN;
                            done_r <= 1'b1;
                            dbz_r  <= 1'b1;
`ifdef MULDIV_FAST_MUL_EN
                        end else if (!op_div) begin
                            hi_r   <= fast_prod[W2-1:WIDTH];
                            lo_r   <= fast_prod[WIDTH-1:0];
                            state  <= FIN;
                            done_r <= 1'b1;
`endif
                        end else begin
                            state <= CALC;
                        end
                    end else begin
                        if (bus.hi_we) hi_r <= bus.wdat;
                        if (bus.lo_we) lo_r <= bus.wdat;
                    end
                end
                CALC: begin
                    acc <= step_acc;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        hi_r   <= res_hi;
                        lo_r   <= res_lo;
                        state  <= FIN;
                        done_r <= 1'b1;
                    end
                end
                FIN: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    dbz_r  <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    dbz_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.div_by_zero = dbz_r;
    assign bus.hi          = hi_r;
    assign bus.lo          = lo_r;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed ops push expected HI/LO/done-cycle,
// a negedge monitor pops and compares on every done pulse.
module tb_muldiv_unit;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int unsigned done_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    int unsigned cyc = 0;
    int          tests_run = 0;
    int          tests_failed = 0;
    exp_t        exp_q[$];
    exp_t        mon_e;

    muldiv_unit_if #(.WIDTH(32)) bus ();

    muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Called at a negedge (cycle 0); start is accepted at the following posedge.
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                                 input logic exp_dbz, input int lat, input bit track);
        exp_t e;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        if (track) begin
            e.hi       = exp_hi;
            e.lo       = exp_lo;
            e.dbz      = exp_dbz;
            e.done_cyc = cyc + lat;
            exp_q.push_back(e);
        end
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic waitIdle(input string name);
        int n;
        n = 0;
        while (bus.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, "_idle"}, {63'b0, bus.busy}, 64'd0);
        @(negedge clk);
    endtask

    // Scoreboard monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_done", {63'b0, bus.done}, 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    checkOutput("done_cycle", 64'(cyc), 64'(mon_e.done_cyc));
                    checkOutput("hi", {32'b0, bus.hi}, {32'b0, mon_e.hi});
                    checkOutput("lo", {32'b0, bus.lo}, {32'b0, mon_e.lo});
                    checkOutput("div_by_zero", {63'b0, bus.div_by_zero}, {63'b0, mon_e.dbz});
                end
            end else begin
                checkOutput("dbz_without_done", {63'b0, bus.div_by_zero}, 64'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.wdat  = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkOutput("reset_busy", {63'b0, bus.busy}, 64'd0);
        checkOutput("reset_done", {63'b0, bus.done}, 64'd0);
        checkOutput("reset_dbz", {63'b0, bus.div_by_zero}, 64'd0);
        checkOutput("reset_hi", {32'b0, bus.hi}, 64'd0);
        checkOutput("reset_lo", {32'b0, bus.lo}, 64'd0);

        // Abort an operation with reset in cycle 10: no done may ever appear.
`ifdef MULDIV_FAST_MUL_EN
        applyStimulus(OP_DIVU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b0, DIV_LAT, 1'b0);
`else
        applyStimulus(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b0, MUL_LAT, 1'b0);
`endif
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_busy", {63'b0, bus.busy}, 64'd0);
        checkOutput("abort_hi", {32'b0, bus.hi}, 64'd0);
        checkOutput("abort_lo", {32'b0, bus.lo}, 64'd0);
        repeat (40) @(negedge clk);
        checkOutput("abort_still_idle", {63'b0, bus.busy}, 64'd0);

        applyStimulus(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, MUL_LAT, 1'b1);
        waitIdle("multu_max");

        // Second start and an MTHI in cycle 5 of a running op must both be ignored.
`ifdef MULDIV_FAST_MUL_EN
        applyStimulus(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, DIV_LAT, 1'b1);
`else
        applyStimulus(OP_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, MUL_LAT, 1'b1);
`endif
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_MULTU;
        bus.a     = 32'd2;
        bus.b     = 32'd2;
        bus.hi_we = 1'b1;
        bus.wdat  = 32'hDEADBEEF;
        @(negedge clk);
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
        checkOutput("hi_we_while_busy", {32'b0, bus.hi}, {32'b0, 32'hFFFFFFFE});
        waitIdle("overlap");

`ifdef MULDIV_FAST_MUL_EN
        applyStimulus(OP_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, MUL_LAT, 1'b1);
        waitIdle("mult_neg");
`else
        applyStimulus(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, DIV_LAT, 1'b1);
        waitIdle("divu_100_7");
`endif

        applyStimulus(OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, DIV_LAT, 1'b1);
        waitIdle("div_neg");

        bus.hi_we = 1'b1;
        bus.wdat  = 32'h00001234;
        @(negedge clk);
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b1;
        bus.wdat  = 32'h00005678;
        @(negedge clk);
        bus.lo_we = 1'b0;
        checkOutput("mthi", {32'b0, bus.hi}, {32'b0, 32'h00001234});
        checkOutput("mtlo", {32'b0, bus.lo}, {32'b0, 32'h00005678});

        applyStimulus(OP_DIV, 32'd5, 32'd0, 32'h00001234, 32'h00005678, 1'b1, 1, 1'b1);
        waitIdle("div_zero");

        applyStimulus(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, DIV_LAT, 1'b1);
        waitIdle("div_overflow");

        bus.hi_we = 1'b1;
        bus.lo_we = 1'b1;
        bus.wdat  = 32'h0000ABCD;
        @(negedge clk);
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        checkOutput("both_we_hi", {32'b0, bus.hi}, {32'b0, 32'h0000ABCD});
        checkOutput("both_we_lo", {32'b0, bus.lo}, {32'b0, 32'h0000ABCD});

        bus.lo_we = 1'b1;
        bus.wdat  = 32'hCAFEBABE;
        @(negedge clk);
        bus.lo_we = 1'b0;
        checkOutput("mtlo_idle", {32'b0, bus.lo}, {32'b0, 32'hCAFEBABE});
        checkOutput("mtlo_keeps_hi", {32'b0, bus.hi}, {32'b0, 32'h0000ABCD});

        // start together with lo_we: the strobe is dropped.
        bus.lo_we = 1'b1;
        bus.wdat  = 32'h11111111;
        applyStimulus(OP_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, MUL_LAT, 1'b1);
        bus.lo_we = 1'b0;
        checkOutput("start_drops_lo_we", {32'b0, bus.lo},
                    {32'b0, (MUL_LAT == 1) ? 32'd15 : 32'hCAFEBABE});
        waitIdle("multu_small");

        checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multi-cycle multiply/divide unit for the single-issue CPU.
- Sits directly downstream of the register file read ports: it takes the two operand read ports (rs/rt values) and holds the HI/LO result pair.
- The decoder reads HI/LO for MFHI/MFLO and writes them for MTHI/MTLO.
- Gives the pipeline a busy/done handshake so it can stall on HI/LO hazards.

Parameters:
- WIDTH, 32, operand and HI/LO width. Only 32 is supported; the parameter exists for bench scaling.
- CNT_W, 6, iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
- start  in  1  request an operation; accepted only while busy=0.
- op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  in  32  operand A (rs / dividend), from register file port A.
- b  in  32  operand B (rt / divisor), from register file port B.
- hi_we  in  1  MTHI strobe.
- lo_we  in  1  MTLO strobe.
- wdat  in  32  MTHI/MTLO data.
- busy  out  1  high while state != IDLE.
- done  out  1  one-cycle pulse; HI/LO hold the result in this cycle.
- div_by_zero  out  1  valid with done; high when DIV/DIVU had b=0.
- hi  out  32  HI register.
- lo  out  32  LO register.

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - state = IDLE.
  - hi = lo = 0.
  - busy = done = div_by_zero = 0.
  - counter and internal datapath registers cleared.
  - Reset mid-operation abandons the operation; no done pulse is produced.
- FSM states: IDLE, CALC, FIN.
- IDLE:
  - If start=1, latch op/a/b and set counter = WIDTH.
    - If op is DIV/DIVU and b=0, go to FIN.
    - Otherwise go to CALC.
  - If start=0 and hi_we/lo_we=1, write wdat to hi/lo at this edge. Both strobes together write both registers.
  - start and hi_we/lo_we together: start wins; the strobes are dropped.
- CALC:
  - One radix-2 step per cycle; counter decrements.
  - Multiply is shift-add on a 64-bit accumulator.
  - Divide is restoring division.
  - When the counter reaches 0, load hi/lo with the result and go to FIN.
- FIN:
  - done=1 for exactly this cycle; go to IDLE next edge.
- Busy-period rules:
  - start while busy=1 is ignored.
  - hi_we/lo_we while busy=1 are ignored; the decoder must stall MTHI/MTLO.
- Latency: with start accepted at the edge ending cycle 0:
  - CALC occupies cycles 1..32.
  - FIN and done occur in cycle 33.
  - The next start can be accepted in cycle 34.
- Signed ops (MULT, DIV):
  - Operate on magnitudes.
  - Product is negated if the signs differ.
  - Quotient is negated if the signs differ.
  - Remainder takes the sign of the dividend.
- Results:
  - MULT/MULTU: {hi,lo} = the 64-bit product.
  - DIV/DIVU: lo = quotient, hi = remainder.
- Boundary cases:
  - DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0 (wraps, no trap).
  - Divide by zero: FIN in cycle 1, done=1, div_by_zero=1, hi/lo unchanged.
  - div_by_zero is 0 whenever done=0.
- hi/lo are stable except at the CALC→FIN edge or an accepted MTHI/MTLO write.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined:
  - MULT/MULTU bypass CALC and use a single-cycle combinational 32x32 multiplier.
  - hi/lo are loaded at the accept edge; FIN and done occur in cycle 1.
  - Divide timing is unchanged.
- Undefined: all multiplies take the 33-cycle iterative path. No combinational multiplier is instantiated.

Test Plan:
- Reset mid-operation: MULTU 0xFFFFFFFF × 0xFFFFFFFF, then assert rst in cycle 10 → busy=0, hi=lo=0, no done pulse. Rerun without rst → done in cycle 33, hi=0xFFFFFFFE, lo=0x00000001.
- MULT 0xFFFFFFFD (-3) × 7 → done in cycle 33, hi=0xFFFFFFFF, lo=0xFFFFFFEB. With MULDIV_FAST_MUL_EN: done in cycle 1, same values.
- DIV 0xFFFFFFF9 (-7) / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIVU 100 / 7 → lo=14, hi=2.
- DIV with b=0 and prior hi=0x1234, lo=0x5678 → done=1 and div_by_zero=1 in cycle 1; hi/lo unchanged.
- DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0, div_by_zero=0.
- Handshake:
  - start asserted again in cycle 5 of a multiply → ignored; exactly one done.
  - hi_we in cycle 5 → hi not written.
  - lo_we with wdat=0xCAFEBABE while idle → lo=0xCAFEBABE next cycle.
  - start together with lo_we → lo_we dropped.
